// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: request size encodings and FSM states.
package sram_ctrl_pkg;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request-side bus of the SRAM controller; DEVICE is the controller view, HOST the requester view.
interface RAM_IF;

    logic [21:0] ADDR;
    logic [31:0] DIN;
    logic [1:0]  DIN_SIZE;
    logic        OE_n;
    logic        WE_n;
    logic        RFSH_n;
    logic [31:0] DOUT;
    logic        ACK_n;
    logic        TIMING;

    modport DEVICE (
        input  ADDR, DIN, DIN_SIZE, OE_n, WE_n, RFSH_n,
        output DOUT, ACK_n, TIMING
    );

    modport HOST (
        output ADDR, DIN, DIN_SIZE, OE_n, WE_n, RFSH_n,
        input  DOUT, ACK_n, TIMING
    );

endinterface

// File: rtl/sram_phase_mux.sv
// Maps a latched request plus phase index onto SRAM address, write data and byte lanes.
module sram_phase_mux
    import sram_ctrl_pkg::*;
(
    input  logic [20:0] addr,
    input  logic [31:0] din,
    input  logic [1:0]  size,
    input  logic        phase,
    output logic [19:0] sram_a,
    output logic [15:0] dq_o,
    output logic        ub_n,
    output logic        lb_n
);

    // Halfword address (second phase wraps at the top) and lane selection per size.
    always_comb begin
        if (phase) begin
            sram_a = addr[20:1] + 20'd1;
        end else begin
            sram_a = addr[20:1];
        end
        case (size)
            SIZE_8: begin
                dq_o = {din[7:0], din[7:0]};
                ub_n = ~addr[0];
                lb_n = addr[0];
            end
            SIZE_32: begin
                dq_o = phase ? din[31:16] : din[15:0];
                ub_n = 1'b0;
                lb_n = 1'b0;
            end
            default: begin
                dq_o = din[15:0];
                ub_n = 1'b0;
                lb_n = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// Bus-to-asynchronous-SRAM controller: edge-triggered requests, 1..2 halfword phases of
// SETUP + WAIT strobe cycles, all SRAM pins registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT = 2
) (
    input  logic        CLK,
    input  logic        RESET_n,
    RAM_IF.DEVICE       Bus,
    output logic [19:0] SRAM_A,
    output logic [15:0] SRAM_DQ_O,
    input  logic [15:0] SRAM_DQ_I,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_WE_n,
    output logic        SRAM_UB_n,
    output logic        SRAM_LB_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

    state_e      state_q, state_d;
    logic        oe_prev_q, we_prev_q, rf_prev_q;
    logic [20:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rlo_q, rlo_d;
    logic [31:0] dout_q, dout_d;
    logic        ack_n_q, ack_n_d;
    logic        timing_q, timing_d;
    logic [19:0] a_q, a_d;
    logic [15:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d, lb_n_q, lb_n_d;

    logic        we_req_s, oe_req_s, rf_req_s, active_s, last_s;
    logic [7:0]  byte_s;
    logic [31:0] rd_word_s;
    logic [19:0] mux_a_s;
    logic [15:0] mux_dq_s;
    logic        mux_ub_n_s, mux_lb_n_s;

    assign we_req_s = we_prev_q & ~Bus.WE_n;
    assign oe_req_s = oe_prev_q & ~Bus.OE_n;
    assign rf_req_s = rf_prev_q & ~Bus.RFSH_n;
    assign last_s   = (cnt_q == WAIT_LAST);
    assign byte_s   = addr_q[0] ? SRAM_DQ_I[15:8] : SRAM_DQ_I[7:0];

    // Assemble the read result for the phase that is finishing.
    always_comb begin
        case (size_q)
            SIZE_8:  rd_word_s = {24'h000000, byte_s};
            SIZE_32: rd_word_s = {SRAM_DQ_I, rlo_q};
            default: rd_word_s = {16'h0000, SRAM_DQ_I};
        endcase
    end

    // FSM next state and request/datapath bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        size_d  = size_q;
        write_d = write_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rlo_d   = rlo_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (we_req_s || oe_req_s || rf_req_s) begin
                    addr_d  = Bus.ADDR[20:0];
                    din_d   = Bus.DIN;
                    size_d  = Bus.DIN_SIZE;
                    phase_d = 1'b0;
                    write_d = we_req_s;
                    state_d = (we_req_s || oe_req_s) ? SETUP : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                state_d = STROBE;
            end
            STROBE: begin
                if (last_s) begin
                    // A 32-bit read parks its low halfword until the high one arrives.
                    if (!write_q && (size_q == SIZE_32) && !phase_q) begin
                        rlo_d = SRAM_DQ_I;
                    end else if (!write_q) begin
                        dout_d = rd_word_s;
                    end else begin
                        dout_d = dout_q;
                    end
                    if ((size_q == SIZE_32) && !phase_q) begin
                        phase_d = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    sram_phase_mux u_phase_mux (
        .addr   (addr_d),
        .din    (din_d),
        .size   (size_d),
        .phase  (phase_d),
        .sram_a (mux_a_s),
        .dq_o   (mux_dq_s),
        .ub_n   (mux_ub_n_s),
        .lb_n   (mux_lb_n_s)
    );

    // Pin and handshake values for the cycle being entered, so they line up with state_q.
    always_comb begin
        active_s = (state_d == SETUP) || (state_d == STROBE);
        ce_n_d   = ~active_s;
        oe_n_d   = ~((state_d == STROBE) && !write_d);
        we_n_d   = ~((state_d == STROBE) && write_d);
        dq_oe_d  = active_s && write_d;
        if (active_s) begin
            a_d    = mux_a_s;
            ub_n_d = mux_ub_n_s;
            lb_n_d = mux_lb_n_s;
        end else begin
            a_d    = a_q;
            ub_n_d = 1'b1;
            lb_n_d = 1'b1;
        end
        if (active_s && write_d) begin
            dq_o_d = mux_dq_s;
        end else begin
            dq_o_d = dq_o_q;
        end
        // A refresh acknowledges for its single DONE cycle.
        ack_n_d  = ~(active_s || ((state_q == IDLE) && (state_d == DONE)));
        timing_d = (state_d == IDLE);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            oe_prev_q <= 1'b1;
            we_prev_q <= 1'b1;
            rf_prev_q <= 1'b1;
            addr_q    <= 21'd0;
            din_q     <= 32'd0;
            size_q    <= 2'd0;
            write_q   <= 1'b0;
            phase_q   <= 1'b0;
            cnt_q     <= 4'd0;
            rlo_q     <= 16'd0;
            dout_q    <= 32'd0;
            ack_n_q   <= 1'b1;
            timing_q  <= 1'b0;
            a_q       <= 20'd0;
            dq_o_q    <= 16'd0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            oe_prev_q <= Bus.OE_n;
            we_prev_q <= Bus.WE_n;
            rf_prev_q <= Bus.RFSH_n;
            addr_q    <= addr_d;
            din_q     <= din_d;
            size_q    <= size_d;
            write_q   <= write_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            rlo_q     <= rlo_d;
            dout_q    <= dout_d;
            ack_n_q   <= ack_n_d;
            timing_q  <= timing_d;
            a_q       <= a_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
        end
    end

    assign Bus.DOUT   = dout_q;
    assign Bus.ACK_n  = ack_n_q;
    assign Bus.TIMING = timing_q;
    assign SRAM_A     = a_q;
    assign SRAM_DQ_O  = dq_o_q;
    assign SRAM_DQ_OE = dq_oe_q;
    assign SRAM_CE_n  = ce_n_q;
    assign SRAM_OE_n  = oe_n_q;
    assign SRAM_WE_n  = we_n_q;
    assign SRAM_UB_n  = ub_n_q;
    assign SRAM_LB_n  = lb_n_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT, default 2: SRAM strobe length in CLK cycles per halfword phase, legal range 1..15.
REQ-002 SHALL have port RESET_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port Bus  RAM_IF.DEVICE  -  request side. Fields: ADDR[21:0] byte address, DIN[31:0], DIN_SIZE[1:0] (0=8b, 1=16b, 2=32b, 3=reserved), OE_n, WE_n, RFSH_n inputs; DOUT[31:0], ACK_n, TIMING outputs.
REQ-005 SHALL have port SRAM_A  output  20  halfword address.
REQ-006 SHALL have ports SRAM_DQ_O output 16, SRAM_DQ_I input 16, SRAM_DQ_OE output 1: split bidirectional data bus; the pad is driven when SRAM_DQ_OE=1.
REQ-007 SHALL have ports SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n  output  1 each  active-low SRAM strobes.

Function
REQ-008 A request SHALL be an H->L edge of Bus.OE_n, Bus.WE_n or Bus.RFSH_n, relative to the value registered on the previous cycle, detected in cycle T0 while in IDLE.
REQ-009 At the end of T0 the block SHALL latch ADDR, DIN and DIN_SIZE, and SHALL drive ACK_n=0 from T1.
REQ-010 Priority on simultaneous edges SHALL be WE > OE > RFSH; lower-priority edges in the same cycle are discarded.
REQ-011 Edges arriving while not in IDLE SHALL be ignored; there is no queueing.
REQ-012 FSM states SHALL be IDLE, SETUP, STROBE and DONE.
- IDLE -> SETUP on an OE or WE request.
- IDLE -> DONE on an RFSH request.
- SETUP -> STROBE after 1 cycle.
- STROBE -> SETUP after WAIT cycles if a second phase is pending, otherwise STROBE -> DONE.
- DONE -> IDLE after 1 cycle.
REQ-013 SETUP SHALL drive SRAM_CE_n=0 and SRAM_A. For writes it SHALL also drive SRAM_DQ_OE=1 and SRAM_DQ_O. SRAM_OE_n and SRAM_WE_n SHALL stay 1.
REQ-014 STROBE SHALL hold the SETUP values and assert SRAM_OE_n=0 (read) or SRAM_WE_n=0 (write).
REQ-015 Read data SHALL be sampled from SRAM_DQ_I on the last STROBE cycle of each phase.
REQ-016 For 8-bit accesses, SRAM_A=ADDR[20:1] and ADDR[0] selects the lane: LB_n=0 when ADDR[0]=0, UB_n=0 when ADDR[0]=1.
- Write: DIN[7:0] is placed on both lanes.
- Read: DOUT={24'h0, selected byte}.
REQ-017 For 16-bit accesses, ADDR[0] SHALL be ignored, both lanes are enabled, and read returns DOUT={16'h0, halfword}.
REQ-018 A 32-bit access SHALL run two phases, low halfword first, at SRAM_A=ADDR[20:1] and then (ADDR[20:1]+1) mod 2^20 (wraps at the top). Write order is DIN[15:0] then DIN[31:16].
REQ-019 DIN_SIZE=3 SHALL be treated as 16-bit.
REQ-020 ADDR[21] SHALL be ignored (2 MiB device).
REQ-021 DOUT SHALL update only on the edge that enters DONE after a read; writes and RFSH SHALL leave DOUT unchanged.
REQ-022 ACK_n SHALL return to 1 in the cycle DONE is entered, so ACK_n is low for 1+WAIT cycles per phase. RFSH gives 1 cycle low, since the SRAM needs no refresh.
REQ-023 TIMING SHALL be 1 exactly while the state is IDLE.
REQ-024 Outside SETUP and STROBE, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n and SRAM_LB_n SHALL be 1 and SRAM_DQ_OE SHALL be 0.
REQ-025 All SRAM outputs SHALL be registered, with no combinational path from Bus to SRAM pins.

Reset
REQ-026 On RESET_n=0, regardless of current state, the block SHALL asynchronously set:
- state=IDLE, ACK_n=1, DOUT=0, TIMING=0 (TIMING becomes 1 the first cycle after release);
- all SRAM strobes 1, SRAM_DQ_OE=0, SRAM_A=0, SRAM_DQ_O=0;
- the previous-value registers for OE_n, WE_n and RFSH_n to 1.
REQ-027 Reset asserted mid-access SHALL abort the access immediately; the SRAM write may be partial.

Structure
REQ-028 A shared package SHALL hold the DIN_SIZE encodings (SIZE_8, SIZE_16, SIZE_32) and the FSM state enum.
REQ-029 One sub-module, sram_phase_mux, SHALL compute SRAM_A, SRAM_DQ_O, UB_n and LB_n from the latched ADDR, DIN, DIN_SIZE and phase index; it is combinational and its outputs are registered in sram_ctrl.
REQ-030 Expected RTL size SHALL be 150-300 lines.

Verification
REQ-031 (WAIT=2) 16-bit read, ADDR=0x000100, SRAM model returns 0xBEEF -> ACK_n low T1..T3, high T4, DOUT=0x0000BEEF, SRAM_A=0x00080.
REQ-032 8-bit write, ADDR=0x000201, DIN=0x5A -> one phase, UB_n=0, LB_n=1, DQ_O=0x5A5A, WE_n low 2 cycles, DOUT unchanged.
REQ-033 32-bit write, ADDR=0x1FFFFE, DIN=0x12345678 -> phase 1 A=0xFFFFF data 0x5678, phase 2 A=0x00000 data 0x1234, ACK_n high at T7.
REQ-034 WE_n and OE_n falling in the same cycle -> write only; an OE_n edge during the busy state is ignored and no second access starts.
REQ-035 RFSH_n edge -> no SRAM strobe, ACK_n low for exactly 1 cycle, TIMING=0 during the busy cycles.
REQ-036 RESET_n asserted during STROBE of a 32-bit read -> all strobes 1, ACK_n=1 and DOUT=0 immediately; a fresh read after release completes normally.
